// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared seven-segment display constants: active-low {g,f,e,d,c,b,a} glyphs.
package seven_seg_scan_ctrl_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A   = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B   = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C   = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F   = 7'h0E;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_decode
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (nibble)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous update,
// blanking, leading-zero suppression and anti-ghost interval.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned TICKS_PER_DIGIT = 50000,
    parameter int unsigned BLANK_TICKS     = 500
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic [NUM_DIGITS-1:0]          blank_in,
    input  logic                           lz_en,
    input  logic                           load,
    output logic                           frame_done,
    output logic [NUM_DIGITS-1:0]          anode,
    output logic [SEG_W-1:0]               segLED,
    output logic                           dp
);

    localparam int unsigned TICK_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned DATA_W = NIBBLE_W * NUM_DIGITS;

    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [IDX_W-1:0]      digit_q, digit_d;
    logic                  tick_wrap, digit_wrap, boundary;

    logic [DATA_W-1:0]     pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0]     act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;

    logic [NUM_DIGITS-1:0] lz_sup;
    logic                  zero_run;
    logic [NIBBLE_W-1:0]   cur_nib;
    logic                  cur_dp, cur_blank, cur_sup;
    logic [NUM_DIGITS-1:0] cur_anode;
    logic [SEG_W-1:0]      dec_seg;

    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;

    // Prescaler and digit index; a frame ends when the last digit's slot wraps.
    always_comb begin
        tick_wrap  = (tick_q == TICK_W'(TICKS_PER_DIGIT - 1));
        digit_wrap = (digit_q == IDX_W'(NUM_DIGITS - 1));
        boundary   = tick_wrap && digit_wrap;
        tick_d     = tick_wrap ? '0 : tick_q + TICK_W'(1);
        digit_d    = digit_q;
        if (tick_wrap) begin
            digit_d = digit_wrap ? '0 : digit_q + IDX_W'(1);
        end
    end

    // Transfer reads the old pending bank, so a coincident load waits one frame.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (boundary && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_data_d  = data_in;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end
    end

    // Leading-zero mask (digit 0 always shown) and current-digit select.
    always_comb begin
        lz_sup   = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_data_q[k*NIBBLE_W +: NIBBLE_W] == '0);
            if (k > 0) begin
                lz_sup[k] = lz_en && zero_run;
            end
        end
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_sup   = 1'b0;
        cur_anode = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_q == IDX_W'(k)) begin
                cur_nib      = act_data_q[k*NIBBLE_W +: NIBBLE_W];
                cur_dp       = act_dp_q[k];
                cur_blank    = act_blank_q[k];
                cur_sup      = lz_sup[k];
                cur_anode[k] = 1'b0;
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg_c  (dec_seg)
    );

    // Output image for the next cycle; anodes stay off during the anti-ghost window.
    always_comb begin
        frame_done_d = boundary;
        anode_d      = '1;
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        if (tick_q >= TICK_W'(BLANK_TICKS)) begin
            anode_d = cur_anode;
            if (!cur_blank) begin
                dp_d = ~cur_dp;
                if (!cur_sup) begin
                    seg_d = dec_seg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q       <= '0;
            digit_q      <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            frame_done_q <= 1'b0;
            anode_q      <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            tick_q       <= tick_d;
            digit_q      <= digit_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            frame_done_q <= frame_done_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign frame_done = frame_done_q;
    assign anode      = anode_q;
    assign segLED     = seg_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (4 digits, 8 ticks/digit, 1 blank tick).
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic        load;
    logic        frame_done;
    logic [3:0]  anode;
    logic [6:0]  segLED;
    logic        dp;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS      (4),
        .TICKS_PER_DIGIT (8),
        .BLANK_TICKS     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .load       (load),
        .frame_done (frame_done),
        .anode      (anode),
        .segLED     (segLED),
        .dp         (dp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until frame_done is seen, bounded to a little over one frame.
    task automatic wait_frame(input string tag);
        logic found;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, ".frame_wait"}, 32'(found), 32'd1);
    endtask

    // Called at a frame_done cycle; checks every cycle of the following frame.
    // segs = {d3,d2,d1,d0} expected glyphs, dps = expected active-low dp per digit.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] an_exp;
            an_exp    = 4'hF;
            an_exp[k] = 1'b0;
            for (int j = 0; j < 8; j++) begin
                step();
                if (j == 0) begin
                    chk($sformatf("%s.d%0d.ghost_anode", tag, k), 32'(anode), 32'hF);
                    chk($sformatf("%s.d%0d.ghost_seg", tag, k), 32'(segLED), 32'h7F);
                    chk($sformatf("%s.d%0d.ghost_dp", tag, k), 32'(dp), 32'd1);
                end else begin
                    chk($sformatf("%s.d%0d.anode", tag, k), 32'(anode), 32'(an_exp));
                    chk($sformatf("%s.d%0d.seg", tag, k), 32'(segLED), 32'(segs[k*7 +: 7]));
                    chk($sformatf("%s.d%0d.dp", tag, k), 32'(dp), 32'(dps[k]));
                end
                chk($sformatf("%s.d%0d.frame_done", tag, k), 32'(frame_done),
                    32'((k == 3) && (j == 7)));
            end
        end
    endtask

    initial begin
        int cnt;
        rst      = 1'b1;
        data_in  = 16'h0000;
        dp_in    = 4'h0;
        blank_in = 4'h0;
        lz_en    = 1'b0;
        load     = 1'b0;

        // Reset held three cycles
        repeat (3) step();
        chk("rst.anode", 32'(anode), 32'hF);
        chk("rst.seg", 32'(segLED), 32'h7F);
        chk("rst.dp", 32'(dp), 32'd1);
        chk("rst.frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        step();
        chk("rel1.anode", 32'(anode), 32'hF);
        step();
        chk("rel2.anode", 32'(anode), 32'hE);
        chk("rel2.seg", 32'(segLED), 32'h40);
        chk("rel2.dp", 32'(dp), 32'd1);

        // Basic frame 12AF
        data_in = 16'h12AF;
        load    = 1'b1;
        step();
        load = 1'b0;
        wait_frame("t2");
        check_frame("t2", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111);

        // Two loads mid-frame: current frame untouched, last value wins next frame
        data_in = 16'h0000;
        load    = 1'b1;
        step();
        data_in = 16'h5555;
        step();
        load = 1'b0;
        repeat (8) step();
        chk("t3.mid.anode", 32'(anode), 32'hD);
        chk("t3.mid.seg", 32'(segLED), 32'h08);
        wait_frame("t3");
        check_frame("t3", {7'h12, 7'h12, 7'h12, 7'h12}, 4'b1111);

        // Leading-zero suppression with dp on a suppressed digit
        lz_en   = 1'b1;
        data_in = 16'h0040;
        dp_in   = 4'b1000;
        load    = 1'b1;
        step();
        load = 1'b0;
        wait_frame("t4a");
        check_frame("t4a", {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b0111);

        data_in = 16'h0000;
        dp_in   = 4'b0000;
        load    = 1'b1;
        step();
        load = 1'b0;
        wait_frame("t4b");
        check_frame("t4b", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);

        // Blank mask on digit 1
        lz_en    = 1'b0;
        data_in  = 16'h12AF;
        blank_in = 4'b0010;
        load     = 1'b1;
        step();
        load = 1'b0;
        wait_frame("t5");
        check_frame("t5", {7'h79, 7'h24, 7'h7F, 7'h0E}, 4'b1111);

        // Reset mid-slot with a pending load that must be discarded
        data_in  = 16'h9999;
        dp_in    = 4'b1111;
        blank_in = 4'b0000;
        load     = 1'b1;
        step();
        load = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("t6.rst.anode", 32'(anode), 32'hF);
        chk("t6.rst.seg", 32'(segLED), 32'h7F);
        chk("t6.rst.dp", 32'(dp), 32'd1);
        chk("t6.rst.frame_done", 32'(frame_done), 32'd0);
        step();
        rst = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (frame_done === 1'b1) begin
                cnt = c;
                break;
            end
        end
        chk("t6.frame_latency", 32'(cnt), 32'd32);
        check_frame("t6", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
